// File: rtl/chip8_pkg.sv
// Shared dimensions and types for the CHIP-8 framebuffer scan path.
package chip8_pkg;

  localparam int CHIP8_W = 64;
  localparam int CHIP8_H = 32;

  typedef logic [31:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/chip8_pix_fifo.sv
// Two-entry show-ahead FIFO holding prefetched VRAM words ahead of the pixel stream.
module chip8_pix_fifo
  import chip8_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push,
  input  pixel_t     push_data,
  input  logic       pop,
  output pixel_t     head,
  output logic [1:0] count
);

  pixel_t mem [2];
  logic   wr_ptr;
  logic   rd_ptr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/chip8_scanout.sv
// Raster-order VRAM reader streaming pixels over valid/ready with integer replication.
//   state | meaning
//   IDLE  | waiting for frame_req
//   RUN   | fetching from VRAM and streaming beats
//   DONE  | one-cycle frame_done pulse
module chip8_scanout
  import chip8_pkg::*;
#(
  parameter int WIDTH  = CHIP8_W,
  parameter int HEIGHT = CHIP8_H,
  parameter int SCALE  = 1,
  parameter int ADDR_W = 11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_req,
  output logic              busy,
  output logic              vram_rd_en,
  output logic [ADDR_W-1:0] vram_rd_addr,
  input  logic [31:0]       vram_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [31:0]       pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_done
);

  localparam logic [15:0] SRC_X_MAX = 16'(WIDTH - 1);
  localparam logic [15:0] SRC_Y_MAX = 16'(HEIGHT - 1);
  localparam logic [15:0] REP_MAX   = 16'(SCALE - 1);
  localparam logic [15:0] OUT_X_MAX = 16'(WIDTH * SCALE - 1);
  localparam logic [15:0] OUT_Y_MAX = 16'(HEIGHT * SCALE - 1);

  scan_state_t state_q, state_d;
  logic [15:0] src_x, src_y, rep_y;
  logic [15:0] rep_x, out_x, out_y;
  logic        fetch_done;
  logic        inflight;
  logic [1:0]  fifo_count;
  pixel_t      fifo_head;
  logic        beat, pop, last_beat, rd_issue;

  chip8_pix_fifo u_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (inflight),
    .push_data (vram_rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign pix_valid = (state_q == RUN) && (fifo_count != 2'd0);
  assign beat      = pix_valid && pix_ready;
  assign pop       = beat && (rep_x == REP_MAX);
  assign last_beat = beat && (out_x == OUT_X_MAX) && (out_y == OUT_Y_MAX);

  // Words already held or on their way must leave room for the next read.
  assign rd_issue = (state_q == RUN) && !fetch_done &&
                    ((3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop)));

  assign vram_rd_en   = rd_issue;
  assign vram_rd_addr = ADDR_W'(src_y) * ADDR_W'(WIDTH) + ADDR_W'(src_x);
  assign pix_data     = pix_valid ? fifo_head : '0;
  assign pix_sof      = pix_valid && (out_x == 16'd0) && (out_y == 16'd0);
  assign pix_eol      = pix_valid && (out_x == OUT_X_MAX);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: if (frame_req) state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
    end
  end

  // Each source row is fetched SCALE times to produce vertical replication.
  always_ff @(posedge clk_in) begin
    if (rst_in || state_q == IDLE) begin
      src_x      <= '0;
      src_y      <= '0;
      rep_y      <= '0;
      fetch_done <= 1'b0;
    end else if (rd_issue) begin
      if (src_x == SRC_X_MAX) begin
        src_x <= '0;
        if (rep_y == REP_MAX) begin
          rep_y <= '0;
          if (src_y == SRC_Y_MAX) begin
            src_y      <= '0;
            fetch_done <= 1'b1;
          end else begin
            src_y <= src_y + 16'd1;
          end
        end else begin
          rep_y <= rep_y + 16'd1;
        end
      end else begin
        src_x <= src_x + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || state_q == IDLE) begin
      rep_x <= '0;
      out_x <= '0;
      out_y <= '0;
    end else if (beat) begin
      rep_x <= (rep_x == REP_MAX) ? '0 : rep_x + 16'd1;
      if (out_x == OUT_X_MAX) begin
        out_x <= '0;
        out_y <= (out_y == OUT_Y_MAX) ? '0 : out_y + 16'd1;
      end else begin
        out_x <= out_x + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_scanout.sv
// Bench for chip8_scanout: scoreboarded frame scans at SCALE 1 and 2, backpressure, ignored requests, mid-frame reset.
module tb_chip8_scanout;
  import chip8_pkg::*;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int AW = 11;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
  } beat_t;

  typedef struct {
    bit sel;
    bit rnd;
    int mid_req;
    bit done_req;
    int exp_beats;
    int exp_lat;
  } vec_t;

  logic clk_in    = 1'b0;
  logic rst_in    = 1'b1;
  logic req       = 1'b0;
  logic pix_ready = 1'b1;
  bit   sel       = 1'b0;
  bit   rnd_ready = 1'b0;

  logic          req1, busy1, rd_en1, valid1, sof1, eol1, done1;
  logic [AW-1:0] addr1;
  logic [31:0]   rdata1, data1;
  logic          req2, busy2, rd_en2, valid2, sof2, eol2, done2;
  logic [AW-1:0] addr2;
  logic [31:0]   rdata2, data2;

  assign req1 = req & ~sel;
  assign req2 = req & sel;

  chip8_scanout #(.WIDTH(W), .HEIGHT(H), .SCALE(1), .ADDR_W(AW)) u_dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .frame_req(req1), .busy(busy1),
    .vram_rd_en(rd_en1), .vram_rd_addr(addr1), .vram_rd_data(rdata1),
    .pix_valid(valid1), .pix_ready(pix_ready), .pix_data(data1),
    .pix_sof(sof1), .pix_eol(eol1), .frame_done(done1)
  );

  chip8_scanout #(.WIDTH(W), .HEIGHT(H), .SCALE(2), .ADDR_W(AW)) u_dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .frame_req(req2), .busy(busy2),
    .vram_rd_en(rd_en2), .vram_rd_addr(addr2), .vram_rd_data(rdata2),
    .pix_valid(valid2), .pix_ready(pix_ready), .pix_data(data2),
    .pix_sof(sof2), .pix_eol(eol2), .frame_done(done2)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] vram_word(input int i);
    logic [15:0] a;
    a = 16'(i);
    return {a ^ 16'hC3A5, a};
  endfunction

  always @(posedge clk_in) begin
    if (rd_en1) rdata1 <= vram_word(int'(addr1));
    if (rd_en2) rdata2 <= vram_word(int'(addr2));
  end

  initial forever begin
    @(posedge clk_in);
    #1;
    pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic          m_busy, m_rd_en, m_valid, m_sof, m_eol, m_done;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  assign m_busy  = sel ? busy2  : busy1;
  assign m_rd_en = sel ? rd_en2 : rd_en1;
  assign m_addr  = sel ? addr2  : addr1;
  assign m_valid = sel ? valid2 : valid1;
  assign m_data  = sel ? data2  : data1;
  assign m_sof   = sel ? sof2   : sof1;
  assign m_eol   = sel ? eol2   : eol1;
  assign m_done  = sel ? done2  : done1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard and stream monitor
  beat_t exp_q[$];
  beat_t mon_cur, mon_exp, prev_beat;
  bit    prev_valid, prev_ready;
  int    beats, mism, extra, stalls, stab_err, fifo_ovf;

  task automatic mon_clear();
    beats = 0; mism = 0; extra = 0; stalls = 0; stab_err = 0;
    prev_valid = 1'b0; prev_ready = 1'b1;
  endtask

  always @(negedge clk_in) begin
    mon_cur = {m_data, m_sof, m_eol};
    if (u_dut1.u_fifo.count > 2'd2 || u_dut2.u_fifo.count > 2'd2) fifo_ovf++;
    if (prev_valid && !prev_ready && (!m_valid || mon_cur != prev_beat)) stab_err++;
    if (m_valid && !pix_ready) stalls++;
    if (m_valid && pix_ready) begin
      beats++;
      if (exp_q.size() == 0) extra++;
      else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp != mon_cur) mism++;
      end
    end
    prev_valid = m_valid;
    prev_ready = pix_ready;
    prev_beat  = mon_cur;
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic build_expected(input int s);
    beat_t b;
    exp_q.delete();
    for (int oy = 0; oy < H * s; oy++) begin
      for (int ox = 0; ox < W * s; ox++) begin
        b.data = vram_word((oy / s) * W + ox / s);
        b.sof  = (ox == 0) && (oy == 0);
        b.eol  = (ox == W * s - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int lat;
    sel = v.sel;
    rnd_ready = v.rnd;
    tick();
    build_expected(v.sel ? 2 : 1);
    mon_clear();
    req = 1'b1;
    tick();
    req = 1'b0;
    lat = 1;
    check({tag, "_start"}, {m_busy, m_rd_en, m_addr}, {1'b1, 1'b1, 11'd0});
    while (!m_done && lat < v.exp_lat + 6000) begin
      tick();
      lat++;
      req = (lat == v.mid_req);
      if (lat == 3) check({tag, "_first_sof"}, {m_valid, m_sof}, 2'b11);
    end
    check({tag, "_done_lat"}, lat, v.exp_lat + stalls);
    req = v.done_req;
    tick();
    req = 1'b0;
    check({tag, "_idle_after"}, {m_busy, m_done}, 2'b00);
    tick();
    check({tag, "_no_second_frame"}, m_busy, 1'b0);
    check({tag, "_beats"}, beats, v.exp_beats);
    check({tag, "_data_mismatches"}, mism, 0);
    check({tag, "_extra_beats"}, extra, 0);
    check({tag, "_missing_beats"}, exp_q.size(), 0);
    check({tag, "_stall_stability"}, stab_err, 0);
    check({tag, "_fifo_overflow"}, fifo_ovf, 0);
    rnd_ready = 1'b0;
  endtask

  task automatic reset_mid_frame(input vec_t v);
    int lat;
    int dones;
    sel = 1'b0;
    rnd_ready = 1'b0;
    tick();
    build_expected(1);
    mon_clear();
    req = 1'b1;
    tick();
    req = 1'b0;
    lat = 1;
    while (beats < 1000 && lat < 5000) begin
      tick();
      lat++;
    end
    check("rst_reached_beat_1000", beats, 1000);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("rst_outputs_zero",
          {busy1, rd_en1, addr1, valid1, data1, sof1, eol1, done1}, 64'd0);
    dones = 0;
    for (int i = 0; i < 2200; i++) begin
      tick();
      if (done1 || busy1) dones++;
    end
    check("rst_no_frame_done", dones, 0);
    run_frame(v, "post_rst");
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 0,    1'b0, 2048, 2051};
    tbl[1] = '{1'b1, 1'b0, 0,    1'b0, 8192, 8195};
    tbl[2] = '{1'b0, 1'b1, 0,    1'b0, 2048, 2051};
    tbl[3] = '{1'b0, 1'b0, 1000, 1'b1, 2048, 2051};
    fifo_ovf = 0;
    mon_clear();

    rst_in = 1'b1;
    repeat (3) tick();
    check("reset_dut1", {busy1, rd_en1, addr1, valid1, data1, sof1, eol1, done1}, 64'd0);
    check("reset_dut2", {busy2, rd_en2, addr2, valid2, data2, sof2, eol2, done2}, 64'd0);
    rst_in = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      run_frame(tbl[i], $sformatf("vec%0d", i));
    end

    reset_mid_frame(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
